// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage and decode's bubble/flush logic.
//   NOP              : bubble instruction (addi x0,x0,0)
//   DEFAULT_RESET_PC : default PC of the first fetch after reset
//   fetch_state_e    : fetch sequencer states (RUN, DROP, HOLD)
//   word_align       : clears the byte-offset bits of an address
package instruction_fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // RUN : a request for pc_r is on the port
  // DROP: the response for pc_r is stale and is discarded, then tgt_r is fetched
  // HOLD: the word for pc_r sits in buf_r waiting for IF/ID to accept it
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory / I-cache fetch port.
//   ic_req   : fetch request (master -> slave)
//   ic_addr  : word-aligned fetch address (master -> slave)
//   ic_rdata : fetched word, valid when ic_ready=1 (slave -> master)
//   ic_ready : response for the current ic_addr this cycle (slave -> master)
interface instruction_fetch_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_ready;

  modport master (output ic_req, ic_addr, input  ic_rdata, ic_ready);
  modport slave  (input  ic_req, ic_addr, output ic_rdata, ic_ready);
endinterface

// File: rtl/instruction_fetch.sv
// Stage 1 of the RV32I pipeline: owns the PC, issues word fetches and drives
// the IF/ID register. Applies decode redirects and hazard holds and honours
// the global memory stall. A one-word buffer (HOLD) and a discard state (DROP)
// make it tolerant of arbitrary memory latency.
//   clk, rst_n     : clock, synchronous active-low reset
//   memory_stall   : global freeze of IF/ID and PC
//   PC_write       : hazard hold; instruction_1 reloaded from IF_DWrite
//   IF_DWrite      : instruction re-presented during a hazard hold
//   IF_flush       : decode flush; redirect when PC_src is also set
//   PC_src         : redirect select
//   branch_address : redirect target (low two bits ignored)
//   ic             : fetch port (master side)
//   instruction_1  : IF/ID instruction
//   PC_1           : IF/ID PC
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       memory_stall,
  input  logic                       PC_write,
  input  logic [31:0]                IF_DWrite,
  input  logic                       IF_flush,
  input  logic                       PC_src,
  input  logic [31:0]                branch_address,
  instruction_fetch_if.master        ic,
  output logic [31:0]                instruction_1,
  output logic [31:0]                PC_1
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_r, pc_n;
  logic [31:0]  buf_r, buf_n;
  logic [31:0]  tgt_r, tgt_n;
  logic [31:0]  inst_n, pc1_n;
  logic         redirect;
  logic [31:0]  target;

  assign redirect = IF_flush & PC_src;
  assign target   = word_align(branch_address);

  assign ic.ic_req  = rst_n & (state != HOLD);
  assign ic.ic_addr = pc_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      pc_r          <= RESET_PC;
      buf_r         <= '0;
      tgt_r         <= '0;
      instruction_1 <= NOP;
      PC_1          <= '0;
    end else begin
      state         <= state_n;
      pc_r          <= pc_n;
      buf_r         <= buf_n;
      tgt_r         <= tgt_n;
      instruction_1 <= inst_n;
      PC_1          <= pc1_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_r;
    buf_n   = buf_r;
    tgt_n   = tgt_r;
    inst_n  = instruction_1;
    pc1_n   = PC_1;

    if (memory_stall || PC_write) begin
      // Both freezes capture an arriving word so the request can retire;
      // decode re-asserts any redirect once the freeze ends.
      if (!memory_stall) inst_n = IF_DWrite;
      if (state == RUN && ic.ic_ready) begin
        buf_n   = ic.ic_rdata;
        state_n = HOLD;
      end
    end else if (redirect) begin
      inst_n = NOP;
      pc1_n  = '0;
      unique case (state)
        RUN: begin
          if (ic.ic_ready) begin
            pc_n = target;
          end else begin
            tgt_n   = target;
            state_n = DROP;
          end
        end
        HOLD: begin
          pc_n    = target;
          state_n = RUN;
        end
        DROP: tgt_n = target;
        default: ;
      endcase
    end else begin
      unique case (state)
        RUN: begin
          if (ic.ic_ready) begin
            inst_n = ic.ic_rdata;
            pc1_n  = pc_r;
            pc_n   = pc_r + 32'd4;
          end else begin
            inst_n = NOP;
            pc1_n  = '0;
          end
        end
        HOLD: begin
          inst_n  = buf_r;
          pc1_n   = pc_r;
          pc_n    = pc_r + 32'd4;
          state_n = RUN;
        end
        DROP: begin
          inst_n = NOP;
          pc1_n  = '0;
          if (ic.ic_ready) begin
            pc_n    = tgt_r;
            state_n = RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] BUBBLE  = 32'h0000_0013;
  localparam logic [31:0] HAZ_INS = 32'h00A5_0533;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memory_stall = 1'b0;
  logic        PC_write = 1'b0;
  logic [31:0] IF_DWrite = '0;
  logic        IF_flush = 1'b0;
  logic        PC_src = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] instruction_1, PC_1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memory_stall   (memory_stall),
    .PC_write       (PC_write),
    .IF_DWrite      (IF_DWrite),
    .IF_flush       (IF_flush),
    .PC_src         (PC_src),
    .branch_address (branch_address),
    .ic             (bus.master),
    .instruction_1  (instruction_1),
    .PC_1           (PC_1)
  );

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.ic_rdata = mem_word(bus.ic_addr);
  initial bus.ic_ready = 1'b0;

  // Reference model: the address the fetcher owes, plus two facts about it --
  // whether its word is already parked, and whether its reply must be thrown away.
  logic [31:0] m_pc = RST_PC, m_parked = '0, m_dest = '0, m_ins = BUBBLE, m_pc1 = '0;
  bit          m_have_word = 0, m_discard = 0;

  function automatic logic [96:0] observed();
    return {bus.ic_req, bus.ic_addr, instruction_1, PC_1};
  endfunction

  function automatic logic [96:0] expected();
    return {rst_n & ~m_have_word, m_pc, m_ins, m_pc1};
  endfunction

  // Advance DUT and model by one clock using the inputs currently driven.
  task automatic tick();
    logic [31:0] pc = m_pc, parked = m_parked, dest = m_dest, ins = m_ins, pc1 = m_pc1;
    bit have = m_have_word, disc = m_discard;
    bit arrives = bus.ic_ready && !m_have_word;
    logic [31:0] t = {branch_address[31:2], 2'b00};
    if (!rst_n) begin
      pc = RST_PC; parked = '0; dest = '0; ins = BUBBLE; pc1 = '0; have = 0; disc = 0;
    end else if (memory_stall || PC_write) begin
      if (!memory_stall) ins = IF_DWrite;
      if (arrives && !disc) begin parked = mem_word(m_pc); have = 1; end
    end else if (IF_flush && PC_src) begin
      ins = BUBBLE; pc1 = '0;
      if (have) begin have = 0; pc = t; end
      else if (disc) dest = t;
      else if (arrives) pc = t;
      else begin dest = t; disc = 1; end
    end else if (have) begin
      ins = parked; pc1 = m_pc; pc = m_pc + 32'd4; have = 0;
    end else if (disc) begin
      ins = BUBBLE; pc1 = '0;
      if (arrives) begin pc = m_dest; disc = 0; end
    end else if (arrives) begin
      ins = mem_word(m_pc); pc1 = m_pc; pc = m_pc + 32'd4;
    end else begin
      ins = BUBBLE; pc1 = '0;
    end
    @(posedge clk);
    m_pc = pc; m_parked = parked; m_dest = dest; m_ins = ins; m_pc1 = pc1;
    m_have_word = have; m_discard = disc;
    @(negedge clk);
  endtask

  task automatic set_in(input bit rst, input bit stall, input bit pcw, input bit fl,
                        input bit src, input logic [31:0] ba, input bit rdy);
    rst_n = rst; memory_stall = stall; PC_write = pcw; IF_flush = fl; PC_src = src;
    branch_address = ba; bus.ic_ready = rdy;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, '0, 1);
    IF_DWrite = HAZ_INS;
    repeat (2) begin
      tick();
      if (observed() !== expected()) begin
        $display("FAIL reset_model got=%h want=%h", observed(), expected()); miscompares++;
      end
      vectors++;
    end
    if ({bus.ic_req, bus.ic_addr, instruction_1, PC_1} !== {1'b0, RST_PC, BUBBLE, 32'h0}) begin
      $display("FAIL reset_values req=%b addr=%h ins=%h pc1=%h want req=0 addr=%h ins=%h pc1=0",
               bus.ic_req, bus.ic_addr, instruction_1, PC_1, RST_PC, BUBBLE); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_sequential();
    set_in(1, 0, 0, 0, 0, '0, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (bus.ic_addr !== RST_PC + 32'(4 * k) || PC_1 !== RST_PC + 32'(4 * (k - 1))) begin
        $display("FAIL seq_addr addr=%h pc1=%h want addr=%h pc1=%h", bus.ic_addr, PC_1,
                 RST_PC + 32'(4 * k), RST_PC + 32'(4 * (k - 1))); miscompares++;
      end
      vectors++;
      if (observed() !== expected()) begin
        $display("FAIL seq_model got=%h want=%h", observed(), expected()); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_redirect();
    set_in(1, 0, 0, 1, 1, 32'h0000_0202, 1);
    tick();
    if ({bus.ic_addr, instruction_1, PC_1} !== {32'h200, BUBBLE, 32'h0}) begin
      $display("FAIL redirect addr=%h ins=%h pc1=%h want addr=200 ins=%h pc1=0",
               bus.ic_addr, instruction_1, PC_1, BUBBLE); miscompares++;
    end
    vectors++;
    set_in(1, 0, 0, 0, 0, '0, 1);
    tick();
    if (PC_1 !== 32'h200 || instruction_1 !== mem_word(32'h200)) begin
      $display("FAIL redirect_target pc1=%h ins=%h want pc1=200 ins=%h",
               PC_1, instruction_1, mem_word(32'h200)); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_redirect_miss();
    logic [31:0] stale = m_pc;
    set_in(1, 0, 0, 1, 1, 32'h0000_0300, 0);
    tick();
    set_in(1, 0, 0, 0, 0, '0, 0);
    repeat (2) begin
      tick();
      if (bus.ic_addr !== stale || instruction_1 !== BUBBLE || bus.ic_req !== 1'b1) begin
        $display("FAIL miss_hold addr=%h ins=%h req=%b want addr=%h ins=%h req=1",
                 bus.ic_addr, instruction_1, bus.ic_req, stale, BUBBLE); miscompares++;
      end
      vectors++;
    end
    bus.ic_ready = 1'b1;
    tick();
    if (bus.ic_addr !== 32'h300 || instruction_1 !== BUBBLE) begin
      $display("FAIL miss_drop addr=%h ins=%h want addr=300 ins=%h",
               bus.ic_addr, instruction_1, BUBBLE); miscompares++;
    end
    vectors++;
    tick();
    if (observed() !== expected()) begin
      $display("FAIL miss_model got=%h want=%h", observed(), expected()); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_hazard();
    logic [31:0] pc1_before = PC_1, fetch_pc = m_pc;
    set_in(1, 0, 1, 1, 0, '0, 1);
    IF_DWrite = HAZ_INS;
    repeat (2) begin
      tick();
      if (instruction_1 !== HAZ_INS || PC_1 !== pc1_before || bus.ic_req !== 1'b0) begin
        $display("FAIL hazard ins=%h pc1=%h req=%b want ins=%h pc1=%h req=0",
                 instruction_1, PC_1, bus.ic_req, HAZ_INS, pc1_before); miscompares++;
      end
      vectors++;
    end
    set_in(1, 0, 0, 0, 0, '0, 1);
    tick();
    if (instruction_1 !== mem_word(fetch_pc) || PC_1 !== fetch_pc || bus.ic_addr !== fetch_pc + 32'd4) begin
      $display("FAIL hazard_release ins=%h pc1=%h addr=%h want ins=%h pc1=%h addr=%h", instruction_1,
               PC_1, bus.ic_addr, mem_word(fetch_pc), fetch_pc, fetch_pc + 32'd4); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_freeze();
    logic [31:0] ins0 = instruction_1, pc0 = PC_1;
    set_in(1, 1, 0, 1, 1, 32'h0000_0700, 1);
    repeat (4) begin
      tick();
      if (instruction_1 !== ins0 || PC_1 !== pc0) begin
        $display("FAIL freeze ins=%h pc1=%h want ins=%h pc1=%h", instruction_1, PC_1, ins0, pc0);
        miscompares++;
      end
      vectors++;
    end
    set_in(1, 0, 0, 1, 1, 32'h0000_0400, 1);
    tick();
    if ({bus.ic_req, bus.ic_addr, instruction_1, PC_1} !== {1'b1, 32'h400, BUBBLE, 32'h0}) begin
      $display("FAIL freeze_redirect req=%b addr=%h ins=%h pc1=%h want req=1 addr=400 ins=%h pc1=0",
               bus.ic_req, bus.ic_addr, instruction_1, PC_1, BUBBLE); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_wrap_and_reset();
    set_in(1, 0, 0, 1, 1, 32'hFFFF_FFFF, 1);
    tick();
    set_in(1, 0, 0, 0, 0, '0, 1);
    tick();
    if (bus.ic_addr !== 32'h0 || PC_1 !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap addr=%h pc1=%h want addr=0 pc1=fffffffc", bus.ic_addr, PC_1); miscompares++;
    end
    vectors++;
    set_in(1, 0, 0, 1, 1, 32'h0000_0500, 0);
    tick();
    set_in(0, 0, 0, 0, 0, '0, 0);
    tick();
    if ({bus.ic_req, bus.ic_addr, instruction_1, PC_1} !== {1'b0, RST_PC, BUBBLE, 32'h0}) begin
      $display("FAIL reset_in_drop req=%b addr=%h ins=%h pc1=%h want req=0 addr=%h ins=%h pc1=0",
               bus.ic_req, bus.ic_addr, instruction_1, PC_1, RST_PC, BUBBLE); miscompares++;
    end
    vectors++;
    set_in(1, 0, 0, 0, 0, '0, 1);
    tick();
    if (PC_1 !== RST_PC || instruction_1 !== mem_word(RST_PC)) begin
      $display("FAIL post_reset pc1=%h ins=%h want pc1=%h ins=%h", PC_1, instruction_1,
               RST_PC, mem_word(RST_PC)); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(99) >= 2, $urandom_range(99) < 15, $urandom_range(99) < 15,
             $urandom_range(99) < 25, $urandom_range(99) < 70, $urandom, $urandom_range(99) < 60);
      IF_DWrite = $urandom;
      tick();
      if (observed() !== expected()) begin
        $display("FAIL random_%0d got=%h want=%h", n, observed(), expected()); miscompares++;
      end
      vectors++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_redirect();
    test_redirect_miss();
    test_hazard();
    test_freeze();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
